// File: rtl/processor_pkg.sv
// Shared processor definitions: store FSM states, sizing constants and the
// word-count clamp used by the store engine.
package processor_pkg;

    localparam int WORDSIZE  = 64;
    localparam int SIZE      = 32;
    localparam int ADDR_W    = 5;
    localparam int CNT_W     = 6;
    localparam int MAX_WORDS = SIZE;

    localparam logic [CNT_W-1:0] COUNT_CLAMP = 6'd32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_RF = 3'd1,
        WR    = 3'd2,
        RB    = 3'd3,
        CHK   = 3'd4,
        DONE  = 3'd5
    } store_state_e;

    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] req);
        if (req > COUNT_CLAMP) begin
            return COUNT_CLAMP;
        end else begin
            return req;
        end
    endfunction

endpackage

// File: rtl/store_ptr.sv
// Wrapping address pointer with load and increment; the increment rolls
// over naturally at the top of the address space.
module store_ptr
    import processor_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr
);

    logic [ADDR_W-1:0] ptr_r;

    // Pointer register: load wins over increment
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= 5'd0;
        end else if (load) begin
            ptr_r <= load_val;
        end else if (inc) begin
            ptr_r <= ptr_r + 5'd1;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/store_unit.sv
// Register-to-memory store engine: copies a run of register_file words into
// data_memory, reading each word back and stopping at the first mismatch.
module store_unit
    import processor_pkg::*;
#(
    parameter int WORDSIZE = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic [ADDR_W-1:0]   src_reg,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [CNT_W-1:0]    count,
    output logic                done_valid,
    input  logic                done_ready,
    output logic                error,
    output logic [ADDR_W-1:0]   err_addr,
    output logic [CNT_W-1:0]    words_done,
    output logic [ADDR_W-1:0]   rf_addr,
    input  logic [WORDSIZE-1:0] rf_data,
    output logic [ADDR_W-1:0]   dm_addr,
    output logic [WORDSIZE-1:0] dm_data_input,
    output logic                dm_write_enable,
    output logic                dm_read,
    input  logic [WORDSIZE-1:0] dm_data_output
);

    store_state_e        state_r;
    store_state_e        state_s;
    logic [CNT_W-1:0]    count_r;
    logic [WORDSIZE-1:0] data_r;
    logic                error_r;
    logic [ADDR_W-1:0]   err_addr_r;
    logic [CNT_W-1:0]    words_done_r;

    logic                load_s;
    logic                capture_s;
    logic                advance_s;
    logic                set_err_s;
    logic [ADDR_W-1:0]   reg_ptr_s;
    logic [ADDR_W-1:0]   mem_ptr_s;
    logic [CNT_W-1:0]    clamped_s;
    logic [CNT_W-1:0]    words_inc_s;
    logic                match_s;

    assign clamped_s   = clamp_count(count);
    assign words_inc_s = words_done_r + 6'd1;
    assign match_s     = (dm_data_output == data_r);

    store_ptr u_reg_ptr (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .load_val (src_reg),
        .inc      (advance_s),
        .ptr      (reg_ptr_s)
    );

    store_ptr u_mem_ptr (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .load_val (dst_addr),
        .inc      (advance_s),
        .ptr      (mem_ptr_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_s   = state_r;
        load_s    = 1'b0;
        capture_s = 1'b0;
        advance_s = 1'b0;
        set_err_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_valid) begin
                    load_s  = 1'b1;
                    state_s = (clamped_s == 6'd0) ? DONE : RD_RF;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_RF: begin
                capture_s = 1'b1;
                state_s   = WR;
            end
            WR: begin
                state_s = RB;
            end
            RB: begin
                state_s = CHK;
            end
            CHK: begin
                if (match_s) begin
                    advance_s = 1'b1;
                    state_s   = (words_inc_s == count_r) ? DONE : RD_RF;
                end else begin
                    set_err_s = 1'b1;
                    state_s   = DONE;
                end
            end
            DONE: begin
                if (done_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Run bookkeeping and captured write data
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r      <= 6'd0;
            data_r       <= {WORDSIZE{1'b0}};
            error_r      <= 1'b0;
            err_addr_r   <= 5'd0;
            words_done_r <= 6'd0;
        end else begin
            if (load_s) begin
                count_r      <= clamped_s;
                error_r      <= 1'b0;
                err_addr_r   <= 5'd0;
                words_done_r <= 6'd0;
            end else if (advance_s) begin
                words_done_r <= words_inc_s;
            end else if (set_err_s) begin
                error_r    <= 1'b1;
                err_addr_r <= mem_ptr_s;
            end else begin
                words_done_r <= words_done_r;
            end
            if (capture_s) begin
                data_r <= rf_data;
            end else begin
                data_r <= data_r;
            end
        end
    end

    // Everything below is decoded from registered state only
    assign start_ready     = (state_r == IDLE);
    assign done_valid      = (state_r == DONE);
    assign dm_write_enable = (state_r == WR);
    assign dm_read         = (state_r == RB);
    assign rf_addr         = reg_ptr_s;
    assign dm_addr         = mem_ptr_s;
    assign dm_data_input   = data_r;
    assign error           = error_r;
    assign err_addr        = err_addr_r;
    assign words_done      = words_done_r;

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit with a register_file model and a data_memory
// model that can corrupt one address on readback.
module tb_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [4:0]  src_reg;
    logic [4:0]  dst_addr;
    logic [5:0]  count;
    logic        done_valid;
    logic        done_ready;
    logic        error;
    logic [4:0]  err_addr;
    logic [5:0]  words_done;
    logic [4:0]  rf_addr;
    logic [63:0] rf_data;
    logic [4:0]  dm_addr;
    logic [63:0] dm_data_input;
    logic        dm_write_enable;
    logic        dm_read;
    logic [63:0] dm_data_output;

    logic [63:0] rf [0:31];
    logic [63:0] dm [0:31];
    int          wr_cnt = 0;
    int          wr_per_addr [0:31];
    logic [4:0]  wlog [0:255];
    int          wlog_n = 0;
    logic        corrupt_en = 1'b0;
    logic [4:0]  corrupt_addr = 5'd0;

    int n_checks = 0;
    int n_fail   = 0;

    store_unit #(.WORDSIZE(64)) dut (
        .clk             (clk),
        .rst             (rst),
        .start_valid     (start_valid),
        .start_ready     (start_ready),
        .src_reg         (src_reg),
        .dst_addr        (dst_addr),
        .count           (count),
        .done_valid      (done_valid),
        .done_ready      (done_ready),
        .error           (error),
        .err_addr        (err_addr),
        .words_done      (words_done),
        .rf_addr         (rf_addr),
        .rf_data         (rf_data),
        .dm_addr         (dm_addr),
        .dm_data_input   (dm_data_input),
        .dm_write_enable (dm_write_enable),
        .dm_read         (dm_read),
        .dm_data_output  (dm_data_output)
    );

    always #5 clk = ~clk;

    assign rf_data = rf[rf_addr];

    initial begin
        for (int i = 0; i < 32; i++) wr_per_addr[i] = 0;
    end

    // data_memory model: write on the edge, registered read, optional corruption
    always @(posedge clk) begin
        if (dm_write_enable) begin
            dm[dm_addr]          <= dm_data_input;
            wr_cnt               <= wr_cnt + 1;
            wr_per_addr[dm_addr] <= wr_per_addr[dm_addr] + 1;
            wlog[wlog_n[7:0]]    <= dm_addr;
            wlog_n               <= wlog_n + 1;
        end
        if (dm_read) begin
            if (corrupt_en && dm_addr == corrupt_addr)
                dm_data_output <= dm[dm_addr] ^ 64'h1;
            else
                dm_data_output <= dm[dm_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accept a run, then return the cycle (accept = cycle 0) where done_valid is first seen
    task automatic start_run(input logic [4:0] s, input logic [4:0] d, input logic [5:0] c,
                             output int cyc);
        @(negedge clk);
        src_reg = s; dst_addr = d; count = c; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        cyc = 1;
        while (!done_valid && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!done_valid) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic release_done();
        @(negedge clk);
        done_ready = 1'b1;
        @(posedge clk); #1;
        done_ready = 1'b0;
        check("release_start_ready", 64'(start_ready), 64'd1);
        check("release_done_valid", 64'(done_valid), 64'd0);
    endtask

    initial begin
        int cyc;
        int base;
        int w10;
        logic [4:0] a;
        logic [4:0] r;

        for (int i = 0; i < 32; i++) rf[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
        rf[0] = 64'd10; rf[1] = 64'd20; rf[2] = 64'd30; rf[3] = 64'd40;
        rst = 1'b1; start_valid = 1'b0; done_ready = 1'b0;
        src_reg = 5'd0; dst_addr = 5'd0; count = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_start_ready", 64'(start_ready), 64'd1);
        check("rst_done_valid", 64'(done_valid), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_err_addr", 64'(err_addr), 64'd0);
        check("rst_words_done", 64'(words_done), 64'd0);
        check("rst_rf_addr", 64'(rf_addr), 64'd0);
        check("rst_dm_addr", 64'(dm_addr), 64'd0);
        check("rst_dm_data_input", dm_data_input, 64'd0);
        check("rst_dm_we", 64'(dm_write_enable), 64'd0);
        check("rst_dm_read", 64'(dm_read), 64'd0);
        @(negedge clk); rst = 1'b0;

        // Basic copy
        start_run(5'd0, 5'd8, 6'd4, cyc);
        check("basic_cycle", 64'(cyc), 64'd17);
        check("basic_error", 64'(error), 64'd0);
        check("basic_words", 64'(words_done), 64'd4);
        check("basic_dm8", dm[8], 64'd10);
        check("basic_dm9", dm[9], 64'd20);
        check("basic_dm10", dm[10], 64'd30);
        check("basic_dm11", dm[11], 64'd40);
        release_done();

        // Zero count
        base = wr_cnt;
        start_run(5'd3, 5'd3, 6'd0, cyc);
        check("zero_cycle", 64'(cyc), 64'd1);
        check("zero_words", 64'(words_done), 64'd0);
        check("zero_writes", 64'(wr_cnt - base), 64'd0);
        release_done();

        // Clamp and wrap
        base = wlog_n;
        start_run(5'd5, 5'd31, 6'd40, cyc);
        check("wrap_cycle", 64'(cyc), 64'd129);
        check("wrap_words", 64'(words_done), 64'd32);
        check("wrap_nwrites", 64'(wlog_n - base), 64'd32);
        for (int i = 0; i < 32; i++) begin
            a = 5'd31 + 5'(i);
            r = 5'd5 + 5'(i);
            check("wrap_addr", 64'(wlog[8'(base + i)]), 64'(a));
            check("wrap_data", dm[a], rf[r]);
        end
        release_done();

        // Readback mismatch on the second word
        corrupt_en = 1'b1; corrupt_addr = 5'd9;
        base = wr_cnt;
        w10 = wr_per_addr[10];
        start_run(5'd0, 5'd8, 6'd4, cyc);
        check("mis_cycle", 64'(cyc), 64'd9);
        check("mis_error", 64'(error), 64'd1);
        check("mis_err_addr", 64'(err_addr), 64'd9);
        check("mis_words", 64'(words_done), 64'd1);
        check("mis_no_wr10", 64'(wr_per_addr[10] - w10), 64'd0);
        check("mis_nwrites", 64'(wr_cnt - base), 64'd2);
        release_done();
        corrupt_en = 1'b0;

        // Reset during the WR of word 2 (cycle 10)
        @(negedge clk);
        src_reg = 5'd0; dst_addr = 5'd16; count = 6'd4; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("rstmid_in_wr", 64'(dm_write_enable), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstmid_start_ready", 64'(start_ready), 64'd1);
        check("rstmid_done_valid", 64'(done_valid), 64'd0);
        check("rstmid_we", 64'(dm_write_enable), 64'd0);
        check("rstmid_rd", 64'(dm_read), 64'd0);
        check("rstmid_dm_addr", 64'(dm_addr), 64'd0);
        check("rstmid_words", 64'(words_done), 64'd0);
        check("rstmid_data_in", dm_data_input, 64'd0);
        @(negedge clk); rst = 1'b0;
        base = wr_cnt;
        repeat (10) @(posedge clk);
        #1;
        check("rstmid_no_writes", 64'(wr_cnt - base), 64'd0);
        start_run(5'd0, 5'd20, 6'd2, cyc);
        check("rstmid_rerun_cycle", 64'(cyc), 64'd9);
        check("rstmid_rerun_error", 64'(error), 64'd0);
        check("rstmid_dm20", dm[20], 64'd10);
        check("rstmid_dm21", dm[21], 64'd20);
        release_done();

        // Handshake hold with start_valid ignored in DONE
        start_run(5'd2, 5'd0, 6'd1, cyc);
        check("hs_cycle", 64'(cyc), 64'd5);
        base = wr_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start_valid = 1'b1; src_reg = 5'd7; dst_addr = 5'd7; count = 6'd3;
            @(posedge clk); #1;
            check("hs_hold_done", 64'(done_valid), 64'd1);
            check("hs_hold_ready", 64'(start_ready), 64'd0);
        end
        @(negedge clk);
        start_valid = 1'b0;
        check("hs_no_writes", 64'(wr_cnt - base), 64'd0);
        check("hs_dm0", dm[0], rf[2]);
        release_done();

        // Back-to-back: start in the first IDLE cycle after release
        start_run(5'd3, 5'd1, 6'd1, cyc);
        check("b2b_cycle", 64'(cyc), 64'd5);
        check("b2b_dm1", dm[1], 64'd40);
        check("b2b_words", 64'(words_done), 64'd1);
        release_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/store_unit.md
# store_unit

Register-to-memory store engine for the processor datapath. It copies a run of consecutive register_file entries into consecutive data_memory locations, reads each stored word back, and checks it. It is the write-back direction of the existing load path, which moves data_memory into register_file. It sits beside the processor FSM and owns one register_file read port plus the data_memory port while busy.

## Interface
- WORDSIZE, 64, data word width
- SIZE, 32, depth of register_file and data_memory; address width is 5 bits

- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start_valid  in  1  request to begin a store run
- start_ready  out  1  high only in IDLE
- src_reg  in  5  first register_file address, sampled on accept
- dst_addr  in  5  first data_memory address, sampled on accept
- count  in  6  number of words to store; 0..63, clamped to 32
- done_valid  out  1  run finished, held until done_ready
- done_ready  in  1  consumer acknowledge of done
- error  out  1  readback mismatch occurred in the finished run; valid with done_valid
- err_addr  out  5  data_memory address of the first mismatch
- words_done  out  6  words written and verified in the current or last run
- rf_addr  out  5  register_file read address; register_file read is combinational
- rf_data  in  WORDSIZE  register_file read data
- dm_addr  out  5  data_memory address
- dm_data_input  out  WORDSIZE  data_memory write data
- dm_write_enable  out  1  data_memory write strobe; write occurs on the rising edge
- dm_read  out  1  data_memory read strobe; data_output is valid the following cycle
- dm_data_output  in  WORDSIZE  data_memory read data

## Operation
- **States:** IDLE, RD_RF, WR, RB, CHK, DONE.
- **IDLE:**
  - start_ready=1.
  - On start_valid, latch src_reg, dst_addr and clamped count, clear error, err_addr and words_done.
  - If the clamped count is 0, go to DONE; otherwise go to RD_RF.
- **RD_RF:** rf_addr = current register pointer; rf_data is captured into the data register at the end of the cycle -> WR.
- **WR:** dm_addr = memory pointer, dm_data_input = captured data, dm_write_enable=1 -> RB.
- **RB:** dm_addr = memory pointer, dm_read=1, dm_write_enable=0 -> CHK.
- **CHK:** compare dm_data_output with the captured data.
  - On mismatch: error=1, err_addr = memory pointer -> DONE.
  - On match:
    - increment words_done, the register pointer and the memory pointer;
    - go to DONE if words_done reaches the count, else to RD_RF.
- **DONE:** done_valid=1; stays until done_ready=1, then IDLE.
- **Pointer width:** both pointers are 5 bits and wrap mod 32 (31 -> 0). With 32 words starting at address 31, the run covers 31, 0..30.
- **Idle outputs:** outside WR/RB, dm_write_enable=0 and dm_read=0. dm_data_input holds its last value.
- **Start during a run:** start_valid outside IDLE is ignored; start_ready=0.
- **Hold in DONE:** error, err_addr and words_done hold their values until the next accepted start.

## Timing
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- **Reset values:**
  - state IDLE, start_ready=1
  - done_valid=0, error=0, err_addr=0, words_done=0
  - rf_addr=0, dm_addr=0, dm_data_input=0
  - dm_write_enable=0, dm_read=0
- **Reset mid-run:** the next cycle is IDLE with all reset values. No write strobe is issued after the reset cycle. Memory contents already written are not undone.
- **Throughput:** 4 cycles per word.
- **Latency:** an accept in cycle 0 gives done_valid high in cycle 4N+1.
  - count=0: done_valid in cycle 1.
  - Mismatch on word k (0-based): done_valid in cycle 4k+5.
- **Done release:** done_valid drops the cycle after done_valid && done_ready. start_ready rises in that same cycle.
- **Back-to-back runs:** done_ready and a new start_valid on consecutive cycles are supported. Minimum gap between runs is 1 IDLE cycle.

## Structure
- **Shared package processor_pkg:**
  - state enum (IDLE, RD_RF, WR, RB, CHK, DONE)
  - ADDR_W=5
  - MAX_WORDS=32
  - count clamp constant
- **Sub-module store_ptr:** a 5-bit wrapping pointer with load and increment, instantiated twice (register pointer and memory pointer).
- **FSM and compare:** stay in store_unit.

## Test plan
- **Basic copy:** preload registers 0..3 = 10, 20, 30, 40; start with src_reg=0, dst_addr=8, count=4.
  - dm words 8..11 = 10, 20, 30, 40.
  - done_valid in cycle 17; error=0, words_done=4.
- **Zero count:** count=0.
  - done_valid in cycle 1; no dm_write_enable pulse; words_done=0.
- **Clamp and wrap:** count=40, src_reg=5, dst_addr=31.
  - 32 writes to addresses 31, 0..30, taking registers 5..31, 0..4.
  - done_valid in cycle 129; words_done=32.
- **Mismatch:** the memory model corrupts address 9 on readback; start dst_addr=8, count=4.
  - error=1, err_addr=9, words_done=1.
  - done_valid in cycle 9; no write to address 10.
- **Reset mid-run:** assert rst during the WR of word 2.
  - IDLE with reset values next cycle; no further dm_write_enable.
  - A new start afterwards completes normally.
- **Handshake:** hold done_ready=0 for 5 cycles.
  - done_valid stays high; start_valid is ignored.
  - On release, start_ready rises the next cycle.
